// File: rtl/qspi_link_pkg.sv
// Shared constants, FSM states and framing helper for the ESP32 QSPI link scheduler.
package qspi_link_pkg;

  localparam int PAYLOAD_W       = 28;
  localparam int HDR_W           = 4;
  localparam int WORD_W          = HDR_W + PAYLOAD_W;
  localparam int MIN_PACE_CYCLES = 40;

  localparam logic [HDR_W-1:0] HDR_KEEPALIVE = 4'h0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    PACE  = 2'd2
  } sched_state_e;

  function automatic logic [WORD_W-1:0] frame_word(input logic [HDR_W-1:0]     hdr,
                                                   input logic [PAYLOAD_W-1:0] payload);
    return {hdr, payload};
  endfunction

endpackage

// File: rtl/qspi_tx_scheduler_if.sv
// Requester/serializer signal bundle of the QSPI tx scheduler; slave = scheduler side.
interface qspi_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  import qspi_link_pkg::*;

  logic                         enable_i;
  logic [NUM_REQ-1:0]           req_valid_i;
  logic [NUM_REQ*PAYLOAD_W-1:0] req_data_i;
  logic [NUM_REQ-1:0]           req_ready_o;
  logic                         ser_wr_o;
  logic [WORD_W-1:0]            ser_data_o;
  logic                         busy_o;

  modport slave (
    input  enable_i, req_valid_i, req_data_i,
    output req_ready_o, ser_wr_o, ser_data_o, busy_o
  );

  modport master (
    output enable_i, req_valid_i, req_data_i,
    input  req_ready_o, ser_wr_o, ser_data_o, busy_o
  );

endinterface

// File: rtl/qspi_rr_arbiter.sv
// Pointer-based round-robin arbiter: grants the first request at or after the pointer,
// and on advance moves the pointer just past the granted requester.
module qspi_rr_arbiter #(
  parameter  int NUM_REQ = 4,
  localparam int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic               clk_i,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req_i,
  input  logic               advance_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   gnt_idx_o,
  output logic               gnt_any_o
);

  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_any_o = 1'b0;
    idx       = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
      if (!gnt_any_o && req_i[idx]) begin
        gnt_any_o      = 1'b1;
        gnt_o[idx]     = 1'b1;
        gnt_idx_o      = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance_i && gnt_any_o)
      ptr_d = (int'(gnt_idx_o) == NUM_REQ - 1) ? '0 : gnt_idx_o + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/qspi_tx_scheduler.sv
// Round-robin QSPI word scheduler: frames requester payloads, paces serializer writes
// so no pending word is overwritten, and emits keepalive words on a quiet link.
module qspi_tx_scheduler
  import qspi_link_pkg::*;
#(
  parameter int NUM_REQ          = 4,
  parameter int PACE_CYCLES      = 40,
  parameter int KEEPALIVE_CYCLES = 4096
) (
  input  logic                clk_i,
  input  logic                rst_n,
  qspi_tx_scheduler_if.slave  bus
);

  localparam int  IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int  PACE_W = $clog2(PACE_CYCLES);
  localparam int  KA_W   = $clog2(KEEPALIVE_CYCLES + 2);
  localparam bit  KA_EN  = (KEEPALIVE_CYCLES != 0);

  sched_state_e                       state_q, state_d;
  logic [WORD_W-1:0]                  word_q, word_d;
  logic [PACE_W-1:0]                  pace_q, pace_d;
  logic [KA_W-1:0]                    ka_q, ka_d;

  logic [NUM_REQ-1:0]                 gnt;
  logic [IDX_W-1:0]                   gnt_idx;
  logic                               gnt_any;
  logic                               advance;
  logic [NUM_REQ-1:0]                 ready;
  logic [NUM_REQ-1:0][PAYLOAD_W-1:0]  payload;

  assign payload = bus.req_data_i;

  qspi_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
    .clk_i     (clk_i),
    .rst_n     (rst_n),
    .req_i     (bus.req_valid_i),
    .advance_i (advance),
    .gnt_o     (gnt),
    .gnt_idx_o (gnt_idx),
    .gnt_any_o (gnt_any)
  );

  // Pulse spacing: ISSUE + (PACE_CYCLES-2) PACE cycles + the granting IDLE cycle.
  // The keepalive fires on the (KEEPALIVE_CYCLES+1)th consecutive quiet IDLE cycle,
  // so a quiet link carries one keepalive every KEEPALIVE_CYCLES+PACE_CYCLES cycles.
  always_comb begin
    state_d = state_q;
    word_d  = word_q;
    pace_d  = pace_q;
    ka_d    = ka_q;
    advance = 1'b0;
    ready   = '0;
    unique case (state_q)
      IDLE: begin
        if (!bus.enable_i) begin
          ka_d = '0;
        end else if (gnt_any) begin
          ready   = gnt;
          advance = 1'b1;
          word_d  = frame_word(HDR_W'(gnt_idx) + HDR_W'(1), payload[gnt_idx]);
          ka_d    = '0;
          state_d = ISSUE;
        end else if (KA_EN && ka_q == KA_W'(KEEPALIVE_CYCLES)) begin
          word_d  = frame_word(HDR_KEEPALIVE, '0);
          ka_d    = '0;
          state_d = ISSUE;
        end else if (KA_EN) begin
          ka_d = ka_q + 1'b1;
        end
      end
      ISSUE: begin
        pace_d  = PACE_W'(PACE_CYCLES - 3);
        ka_d    = '0;
        state_d = PACE;
      end
      PACE: begin
        ka_d = '0;
        if (pace_q == '0) state_d = IDLE;
        else              pace_d  = pace_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      pace_q  <= '0;
      ka_q    <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      pace_q  <= pace_d;
      ka_q    <= ka_d;
    end
  end

  // ready is combinational from valid; gate it so reset silences it immediately
  assign bus.req_ready_o = ready & {NUM_REQ{rst_n}};
  assign bus.ser_wr_o    = (state_q == ISSUE);
  assign bus.ser_data_o  = word_q;
  assign bus.busy_o      = (state_q != IDLE);

endmodule

// File: tb/tb_qspi_tx_scheduler.sv
// Self-checking bench: vector table, multi-cycle corner sequences, and a serializer
// model with a scoreboard of expected framed words.
module tb_qspi_tx_scheduler;

  localparam int N = 4;
  localparam int P = 40;
  localparam int K = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  qspi_tx_scheduler_if #(.NUM_REQ(N)) bus ();

  qspi_tx_scheduler #(.NUM_REQ(N), .PACE_CYCLES(P), .KEEPALIVE_CYCLES(K)) dut (
    .clk_i (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [3:0]        valid;
    logic [3:0][27:0]  data;
    logic [3:0]        exp_rdy;
    logic [31:0]       exp_word;
  } vec_t;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          grant_log[$];
  int          model_ptr = 0;
  int          ser_busy = 0;
  int          nib_cnt = 0;
  logic [31:0] sh, rebuilt, cur_exp;
  int          cyc = 0;
  int          last_wr = 0;
  bit          have_last = 0;
  bit          exact_gap = 0;
  logic [N-1:0] hs_mask = '0;
  int          n_xfer = 0;
  int          n_ka = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic int model_grant(input logic [N-1:0] v, input int ptr);
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
      if (v[idx]) return idx;
    end
    return -1;
  endfunction

  // Monitor: reference arbiter, scoreboard push on handshake, serializer model on write.
  always @(negedge clk) begin
    if (!rst_n) begin
      model_ptr = 0;
      ser_busy  = 0;
      nib_cnt   = 0;
      have_last = 0;
      hs_mask   = '0;
      exp_q.delete();
    end else begin
      int gi;
      cyc++;
      hs_mask = bus.req_ready_o & bus.req_valid_i;
      if (bus.req_ready_o != '0) begin
        gi = model_grant(bus.req_valid_i, model_ptr);
        chk("grant", 32'(bus.req_ready_o), (gi < 0) ? 32'h0 : (32'h1 << gi));
        if (gi >= 0) begin
          exp_q.push_back({4'(gi + 1), bus.req_data_i[28*gi +: 28]});
          grant_log.push_back(gi);
          n_xfer++;
          model_ptr = (gi + 1) % N;
        end
      end
      if (nib_cnt > 0) begin
        rebuilt[4*(8-nib_cnt) +: 4] = sh[3:0];
        sh = sh >> 4;
        nib_cnt--;
        if (nib_cnt == 0) chk("ser_word", rebuilt, cur_exp);
      end
      if (ser_busy > 0) ser_busy--;
      if (bus.ser_wr_o) begin
        chk("ser_overwrite", 32'(ser_busy), 32'h0);
        if (have_last) begin
          if (exact_gap) chk("wr_gap", 32'(cyc - last_wr), 32'(P));
          else           chk("wr_gap_min", 32'(cyc - last_wr >= P), 32'h1);
        end
        have_last = 1;
        last_wr   = cyc;
        if (exp_q.size() > 0) cur_exp = exp_q.pop_front();
        else begin
          cur_exp = 32'h0;
          n_ka++;
        end
        sh       = bus.ser_data_o;
        rebuilt  = '0;
        nib_cnt  = 8;
        ser_busy = P;
      end
    end
  end

  task automatic wait_idle();
    bit ok;
    ok = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (!bus.busy_o) begin
        ok = 1;
        break;
      end
    end
    if (!ok) chk("idle_timeout", 32'h1, 32'h0);
  endtask

  vec_t tbl[7];

  initial begin
    int cnt;
    bit found, bad;
    int n0;

    tbl[0] = '{4'b0100, {28'h0, 28'hABCDEF1, 28'h0, 28'h0}, 4'b0100, 32'h3ABCDEF1};
    tbl[1] = '{4'b0011, {28'h0, 28'h0, 28'h1000002, 28'h1000001}, 4'b0001, 32'h11000001};
    tbl[2] = '{4'b1010, {28'h2333333, 28'h0, 28'h2222222, 28'h0}, 4'b0010, 32'h22222222};
    tbl[3] = '{4'b1001, {28'h3FFFFFF, 28'h0, 28'h0, 28'h3000000}, 4'b1000, 32'h43FFFFFF};
    tbl[4] = '{4'b1111, {28'h4000003, 28'h4000002, 28'h4000001, 28'h4000000}, 4'b0001, 32'h14000000};
    tbl[5] = '{4'b0001, {28'h0, 28'h0, 28'h0, 28'hFFFFFFF}, 4'b0001, 32'h1FFFFFFF};
    tbl[6] = '{4'b1000, {28'h0, 28'h0, 28'h0, 28'h0}, 4'b1000, 32'h40000000};

    bus.enable_i    = 1'b1;
    bus.req_valid_i = 4'b1111;
    bus.req_data_i  = {28'h1234567, 28'h89ABCDE, 28'hF012345, 28'h6789ABC};

    // reset state, with every requester valid so a leaky ready would show
    repeat (2) @(negedge clk);
    chk("rst_ready", 32'(bus.req_ready_o), 32'h0);
    chk("rst_wr",    32'(bus.ser_wr_o),    32'h0);
    chk("rst_data",  bus.ser_data_o,       32'h0);
    chk("rst_busy",  32'(bus.busy_o),      32'h0);
    bus.req_valid_i = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // table-driven single grants, walking the round-robin pointer
    for (int i = 0; i < 7; i++) begin
      wait_idle();
      bus.req_valid_i = tbl[i].valid;
      bus.req_data_i  = tbl[i].data;
      @(negedge clk);
      chk("tbl_ready", 32'(bus.req_ready_o), 32'(tbl[i].exp_rdy));
      @(posedge clk); #1;
      bus.req_valid_i = '0;
      @(negedge clk);
      chk("tbl_wr",   32'(bus.ser_wr_o), 32'h1);
      chk("tbl_word", bus.ser_data_o,    tbl[i].exp_word);
    end

    // fairness: all valid continuously, pulses exactly P apart
    wait_idle();
    grant_log.delete();
    have_last = 0;
    exact_gap = 1;
    bus.req_data_i  = {28'h5A00003, 28'h5A00002, 28'h5A00001, 28'h5A00000};
    bus.req_valid_i = 4'b1111;
    found = 0;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      if (grant_log.size() >= 5) begin
        found = 1;
        break;
      end
    end
    bus.req_valid_i = '0;
    chk("fair_timeout", 32'(found), 32'h1);
    for (int k = 0; k < 5; k++)
      if (grant_log.size() > k) chk("fair_order", 32'(grant_log[k]), 32'(k % 4));

    // keepalive timing on a quiet link
    wait_idle();
    exact_gap = 0;
    cnt = 0;
    found = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (bus.ser_wr_o) begin
        found = 1;
        break;
      end
      @(posedge clk); #1;
      cnt++;
    end
    chk("ka_first_cycle", 32'(cnt), 32'(K + 1));
    chk("ka_first_word",  bus.ser_data_o, 32'h0);
    cnt = 0;
    for (int c = 0; c < 200; c++) begin
      @(posedge clk); #1;
      cnt++;
      @(negedge clk);
      if (bus.ser_wr_o) break;
    end
    chk("ka_period", 32'(cnt), 32'(K + P));

    // request on the keepalive expiry cycle wins
    for (int c = 0; c < K + P - 1; c++) @(posedge clk);
    #1;
    bus.req_data_i  = {28'h0, 28'h0, 28'h0, 28'h6C0FFEE};
    bus.req_valid_i = 4'b0001;
    @(negedge clk);
    chk("ka_collide_ready", 32'(bus.req_ready_o), 32'h1);
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    @(negedge clk);
    chk("ka_collide_word", bus.ser_data_o, 32'h16C0FFEE);

    // enable low: nothing granted, no keepalive; grant as soon as it rises
    @(posedge clk); #1;
    bus.enable_i    = 1'b0;
    bus.req_data_i  = {28'h0, 28'h0, 28'h7777777, 28'h0};
    bus.req_valid_i = 4'b0010;
    bad = 0;
    for (int c = 0; c < 120; c++) begin
      @(negedge clk);
      if (bus.req_ready_o != '0 || bus.ser_wr_o) bad = 1;
    end
    chk("en_low_quiet", 32'(bad), 32'h0);
    @(posedge clk); #1;
    bus.enable_i = 1'b1;
    @(negedge clk);
    chk("en_rise_ready", 32'(bus.req_ready_o), 32'h2);
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    @(negedge clk);
    chk("en_rise_word", bus.ser_data_o, 32'h27777777);

    // reset mid-PACE after a req 3 issue
    wait_idle();
    bus.req_data_i  = {28'h8BADF00, 28'h0, 28'h0, 28'h0};
    bus.req_valid_i = 4'b1000;
    @(negedge clk);
    chk("r3_ready", 32'(bus.req_ready_o), 32'h8);
    @(posedge clk); #1;
    bus.req_valid_i = '0;
    @(negedge clk);
    chk("r3_word", bus.ser_data_o, 32'h48BADF00);
    repeat (20) @(posedge clk);
    #1;
    bus.req_data_i  = {28'h3E3E3E3, 28'h0, 28'h0, 28'h0D0D0D0};
    bus.req_valid_i = 4'b1001;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", 32'(bus.req_ready_o), 32'h0);
    chk("midrst_wr",    32'(bus.ser_wr_o),    32'h0);
    chk("midrst_data",  bus.ser_data_o,       32'h0);
    chk("midrst_busy",  32'(bus.busy_o),      32'h0);
    grant_log.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_ready", 32'(bus.req_ready_o), 32'h1);
    @(posedge clk); #1;
    bus.req_valid_i = 4'b1000;
    found = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge clk); #1;
      if (grant_log.size() >= 2) begin
        found = 1;
        break;
      end
    end
    bus.req_valid_i = '0;
    chk("postrst_timeout", 32'(found), 32'h1);
    if (grant_log.size() >= 2) begin
      chk("postrst_first",  32'(grant_log[0]), 32'h0);
      chk("postrst_second", 32'(grant_log[1]), 32'h3);
    end

    // random back-to-back traffic through the serializer model
    wait_idle();
    n0 = n_xfer;
    for (int c = 0; c < 60000 && (n_xfer - n0) < 1000; c++) begin
      @(posedge clk); #1;
      for (int i = 0; i < N; i++) begin
        if (hs_mask[i]) bus.req_valid_i[i] = 1'b0;
        else if (bus.req_valid_i[i] && $urandom_range(0, 63) == 0) bus.req_valid_i[i] = 1'b0;
        else if (!bus.req_valid_i[i] && $urandom_range(0, 3) == 0) begin
          bus.req_valid_i[i] = 1'b1;
          bus.req_data_i[28*i +: 28] = 28'($urandom);
        end
      end
    end
    bus.req_valid_i = '0;
    chk("rand_count", 32'((n_xfer - n0) >= 1000), 32'h1);
    wait_idle();
    repeat (10) @(posedge clk);
    #1;
    chk("rand_queue_empty", 32'(exp_q.size()), 32'h0);
    chk("rand_nibbles_done", 32'(nib_cnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
